// File: rtl/seg7_pkg.sv
`default_nettype none
// ==========================================================================
// seg7_pkg : shared 7-segment types and segment code constants.  Rev 1.0
// ==========================================================================
package seg7_pkg;

  typedef logic [6:0] seg7_t;   // {g,f,e,d,c,b,a}, active high
  typedef logic [3:0] bcd_t;

  localparam seg7_t SEG_BLANK = 7'h00;
  localparam seg7_t SEG_ERR   = 7'h79;

  localparam seg7_t SEG_0 = 7'h3F;
  localparam seg7_t SEG_1 = 7'h06;
  localparam seg7_t SEG_2 = 7'h5B;
  localparam seg7_t SEG_3 = 7'h4F;
  localparam seg7_t SEG_4 = 7'h66;
  localparam seg7_t SEG_5 = 7'h6D;
  localparam seg7_t SEG_6 = 7'h7D;
  localparam seg7_t SEG_7 = 7'h07;
  localparam seg7_t SEG_8 = 7'h7F;
  localparam seg7_t SEG_9 = 7'h6F;

  localparam int BCD_W = 4;

endpackage
`default_nettype wire

// File: rtl/seg7_bcd_decode.sv
`default_nettype none
// ==========================================================================
// seg7_bcd_decode : combinational BCD to segment decoder, non-BCD -> 'E'.  Rev 1.0
// ==========================================================================
module seg7_bcd_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_ERR;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_ERR;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ==========================================================================
// seg7_scan_ctrl : N-digit multiplexed 7-seg scanner with tear-free frame load.  Rev 1.0
// ==========================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      lz_en,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  output logic [6:0]                seg,
  output logic [NUM_DIGITS-1:0]     dig_en,
  output logic                      frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = BCD_W * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [FW-1:0]          active_q, active_d;
  logic [FW-1:0]          pending_q, pending_d;
  logic                   pending_full_q, pending_full_d;
  logic [6:0]             seg_q, seg_d;
  logic [NUM_DIGITS-1:0]  dig_en_q, dig_en_d;
  logic                   frame_start_q, frame_start_d;

  logic                   boundary;
  logic                   accept;
  logic                   commit;
  logic [NUM_DIGITS-1:0]  lz_supp;
  logic [3:0]             digit_sel;
  logic [6:0]             dec_seg;

  // Frame buffer and handshake: pending only moves into active at a boundary
  // or while the display is dark, so a frame is never shown half-updated.
  always_comb begin
    boundary       = enable && (cnt_q == '0) && (idx_q == '0);
    accept         = load_valid && !pending_full_q;
    commit         = pending_full_q && (boundary || !enable);
    active_d       = commit ? pending_q : active_q;
    pending_d      = accept ? load_data : pending_q;
    pending_full_d = pending_full_q;
    if (accept) begin
      pending_full_d = 1'b1;
    end else if (commit) begin
      pending_full_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = '0;
    idx_d = '0;
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
      end
    end
  end

  // Scan downward from the MSD: a digit is suppressed while it and all
  // digits above it are zero; digit 0 always shows.
  always_comb begin
    logic run_zero;
    run_zero = 1'b1;
    lz_supp  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero   = run_zero && (active_d[BCD_W*k +: BCD_W] == 4'd0);
      lz_supp[k] = lz_en && run_zero && (k != 0);
    end
  end

  always_comb begin
    digit_sel = active_d[BCD_W*int'(idx_q) +: BCD_W];
  end

  seg7_bcd_decode u_decode (
    .bcd_i (digit_sel),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d         = SEG_BLANK;
    dig_en_d      = '0;
    frame_start_d = boundary;
    if (enable && (int'(cnt_q) >= BLANK_CYCLES)) begin
      dig_en_d = NUM_DIGITS'(1) << idx_q;
      seg_d    = lz_supp[idx_q] ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      seg_q          <= SEG_BLANK;
      dig_en_q       <= '0;
      frame_start_q  <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      seg_q          <= seg_d;
      dig_en_q       <= dig_en_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign load_ready  = !pending_full_q;
  assign seg         = seg_q;
  assign dig_en      = dig_en_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_seg7_scan_ctrl : scoreboard bench, NUM_DIGITS=4 REFRESH_DIV=4 BLANK_CYCLES=1.  Rev 1.0
// ==========================================================================
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        lz_en = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .lz_en       (lz_en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .seg         (seg),
    .dig_en      (dig_en),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
  } obs_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] act;
    logic [15:0] exp;
  } chk_t;

  localparam logic [7:0] ID_RST_SEG = 0, ID_RST_DIG = 1, ID_RST_FS = 2, ID_RST_RDY = 3,
                         ID_SCAN_DIG = 4, ID_FS_PERIOD = 5, ID_STALL = 6,
                         ID_DIS_DIG = 7, ID_DIS_SEG = 8, ID_DIS_FS = 9, ID_DIS_RDY = 10,
                         ID_REEN_FS = 11, ID_PRE_RDY = 12, ID_TIMEOUT = 13;

  obs_t exp_q[$];
  chk_t chk_q[$];
  int   tests = 0;
  int   fails = 0;
  int   req_id = 0;
  int   ack_id = 0;

  function automatic string name_of(input logic [7:0] id);
    case (id)
      ID_RST_SEG:   return "reset_seg";
      ID_RST_DIG:   return "reset_dig_en";
      ID_RST_FS:    return "reset_frame_start";
      ID_RST_RDY:   return "reset_load_ready";
      ID_SCAN_DIG:  return "scan_dig_en";
      ID_FS_PERIOD: return "frame_start_period";
      ID_STALL:     return "load_stall";
      ID_DIS_DIG:   return "disable_dig_en";
      ID_DIS_SEG:   return "disable_seg";
      ID_DIS_FS:    return "disable_frame_start";
      ID_DIS_RDY:   return "disable_commit_ready";
      ID_REEN_FS:   return "reenable_frame_start";
      ID_PRE_RDY:   return "pending_full_before_reset";
      default:      return "timeout";
    endcase
  endfunction

  // Monitor: sole comparer. Checks posted records every cycle and, once armed
  // on a frame_start, pops one expected (dig_en, seg) per lit digit cycle.
  initial begin : monitor
    bit   armed;
    obs_t e;
    chk_t c;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      while (chk_q.size() != 0) begin
        c = chk_q.pop_front();
        tests++;
        if (c.act !== c.exp) begin
          fails++;
          $display("FAIL %s: got %0h, expected %0h", name_of(c.id), c.act, c.exp);
        end
      end
      if (!armed && (req_id != ack_id) && (frame_start === 1'b1)) begin
        armed  = 1'b1;
        ack_id = req_id;
      end else if (armed && (dig_en !== 4'b0)) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          tests++;
          if ({dig_en, seg} !== {e.dig, e.seg}) begin
            fails++;
            $display("FAIL frame_digit: got dig_en=%h seg=%h, expected dig_en=%h seg=%h",
                     dig_en, seg, e.dig, e.seg);
          end
        end
        if (exp_q.size() == 0) armed = 1'b0;
      end
    end
  end

  task automatic post(input logic [7:0] id, input logic [15:0] act, input logic [15:0] exp);
    chk_q.push_back('{id: id, act: act, exp: exp});
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++)
      for (int r = 0; r < 3; r++)
        exp_q.push_back('{dig: 4'(1 << d), seg: s[d]});
    req_id++;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (((exp_q.size() != 0) || (req_id != ack_id)) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      post(ID_TIMEOUT, 16'd1, 16'd0);
      exp_q.delete();
      ack_id = req_id;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while ((load_ready !== 1'b1) && (n < 64)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) post(ID_TIMEOUT, 16'd2, 16'd0);
  endtask

  task automatic wait_fs();
    int n = 0;
    while ((frame_start !== 1'b1) && (n < 64)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) post(ID_TIMEOUT, 16'd3, 16'd0);
  endtask

  task automatic load(input logic [15:0] d);
    int n = 0;
    load_data  = d;
    load_valid = 1'b1;
    while ((load_ready !== 1'b1) && (n < 64)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) post(ID_TIMEOUT, 16'd4, 16'd0);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin : stimulus
    @(negedge clk);
    post(ID_RST_SEG, 16'(seg), 16'h00);
    post(ID_RST_DIG, 16'(dig_en), 16'h0);
    post(ID_RST_FS,  16'(frame_start), 16'h0);
    post(ID_RST_RDY, 16'(load_ready), 16'h1);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // 1: 1234, blanking pattern, frame period and digit codes
    load(16'h1234);
    wait_ready();
    wait_fs();
    for (int j = 0; j < 16; j++) begin
      post(ID_SCAN_DIG, 16'(dig_en), ((j % 4) == 0) ? 16'h0 : 16'(1 << (j / 4)));
      @(negedge clk);
    end
    post(ID_FS_PERIOD, 16'(frame_start), 16'h1);
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
    wait_drain();

    // 2: second load stalls until 0000 commits
    load(16'h0000);
    load_valid = 1'b1;
    load_data  = 16'h5678;
    post(ID_STALL, 16'(load_ready), 16'h0);
    load(16'h5678);
    wait_ready();
    push_frame(7'h7F, 7'h07, 7'h7D, 7'h6D);
    wait_drain();

    // 3: leading-zero suppression
    lz_en = 1'b1;
    load(16'h0070);
    wait_ready();
    push_frame(7'h3F, 7'h07, 7'h00, 7'h00);
    wait_drain();
    load(16'h0000);
    wait_ready();
    push_frame(7'h3F, 7'h00, 7'h00, 7'h00);
    wait_drain();

    // 4: non-BCD codes
    lz_en = 1'b0;
    load(16'hFA9C);
    wait_ready();
    push_frame(7'h79, 7'h6F, 7'h79, 7'h79);
    wait_drain();

    // 5: disable with a pending frame, then re-enable
    wait_ready();
    load(16'h0042);
    enable = 1'b0;
    @(negedge clk);
    post(ID_DIS_DIG, 16'(dig_en), 16'h0);
    post(ID_DIS_SEG, 16'(seg), 16'h00);
    post(ID_DIS_FS,  16'(frame_start), 16'h0);
    post(ID_DIS_RDY, 16'(load_ready), 16'h1);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    push_frame(7'h5B, 7'h66, 7'h3F, 7'h3F);
    @(negedge clk);
    post(ID_REEN_FS, 16'(frame_start), 16'h1);
    wait_drain();

    // 6: async reset mid-slot with pending_full
    wait_fs();
    load(16'h9999);
    post(ID_PRE_RDY, 16'(load_ready), 16'h0);
    #1 rst_n = 1'b0;
    #1;
    post(ID_RST_SEG, 16'(seg), 16'h00);
    post(ID_RST_DIG, 16'(dig_en), 16'h0);
    post(ID_RST_FS,  16'(frame_start), 16'h0);
    post(ID_RST_RDY, 16'(load_ready), 16'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
